// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter handing out one fresh 20-bit Fibonacci LFSR word per grant, with reseed and warm-up.
// Optional statistics (grant_count, starve_flag) are compiled in with LFSR_RNG_ARB_STATS_EN.
module lfsr_rng_arbiter #(
   parameter int          NUM_REQ = 4,
   parameter logic [19:0] SEED    = 20'h00001,
   parameter int          WARMUP  = 20
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   input  logic               seed_load,
   input  logic [19:0]        seed_in,
   output logic [NUM_REQ-1:0] grant,
   output logic [19:0]        rand_out,
   output logic               rand_valid,
   output logic               busy
`ifdef LFSR_RNG_ARB_STATS_EN
   ,
   output logic [15:0]        grant_count,
   output logic [NUM_REQ-1:0] starve_flag
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [9:0] WARM_INIT = 10'(WARMUP);

   typedef enum logic {WARM, READY} state_t;
   localparam state_t INIT_STATE = (WARMUP == 0) ? READY : WARM;

   state_t          state;
   logic [19:0]     lfsr;
   logic [19:0]     lfsr_next;
   logic [9:0]      warm_cnt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   pick_idx;
   logic [PW-1:0]   ptr_next;
   logic            pick_vld;
   logic            fire;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PW'(s);
   endfunction

   assign lfsr_next = {lfsr[18:0], lfsr[19] ^ lfsr[16]};

   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[wrap_idx(rr_ptr, k)]) begin
            pick_vld = 1'b1;
            pick_idx = wrap_idx(rr_ptr, k);
         end
      end
   end

   assign ptr_next = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + PW'(1);
   assign fire     = !seed_load && (state == READY) && en && pick_vld;
   assign busy     = (state == WARM);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= INIT_STATE;
         lfsr       <= SEED;
         warm_cnt   <= WARM_INIT;
         rr_ptr     <= '0;
         grant      <= '0;
         rand_out   <= '0;
         rand_valid <= 1'b0;
      end else begin
         grant      <= '0;
         rand_valid <= 1'b0;
         if (seed_load) begin
            // A zero seed would lock the LFSR, so fall back to SEED.
            lfsr     <= (seed_in == 20'd0) ? SEED : seed_in;
            warm_cnt <= WARM_INIT;
            state    <= INIT_STATE;
         end else if (state == WARM) begin
            lfsr     <= lfsr_next;
            warm_cnt <= warm_cnt - 10'd1;
            if (warm_cnt == 10'd1) state <= READY;
         end else if (fire) begin
            grant      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            rand_out   <= lfsr;
            rand_valid <= 1'b1;
            lfsr       <= lfsr_next;
            rr_ptr     <= ptr_next;
         end
      end
   end

`ifdef LFSR_RNG_ARB_STATS_EN
   localparam int STARVE = 2 * NUM_REQ;

   logic [5:0] wait_cnt [NUM_REQ];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         grant_count <= '0;
         starve_flag <= '0;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      end else begin
         if (fire && grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (state == READY && req[i] && !(fire && pick_idx == PW'(i))) begin
               if (wait_cnt[i] == 6'(STARVE - 1)) starve_flag[i] <= 1'b1;
               else                                wait_cnt[i]    <= wait_cnt[i] + 6'd1;
            end else begin
               wait_cnt[i] <= '0;
            end
         end
      end
   end
`endif

endmodule
